// File: rtl/carry_skip_pipe_if.sv
// Operand/result handshake bundle for the pipelined carry-skip adder/subtractor.
// The producer/consumer side uses master; the adder uses slave.
interface carry_skip_pipe_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] operand1;
   logic [WIDTH-1:0] operand2;
   logic             Cin;
   logic             sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] Result;
   logic             Cout;
   logic             Overflow;

   modport master (
      output in_valid, operand1, operand2, Cin, sub, out_ready,
      input  in_ready, out_valid, Result, Cout, Overflow
   );

   modport slave (
      input  in_valid, operand1, operand2, Cin, sub, out_ready,
      output in_ready, out_valid, Result, Cout, Overflow
   );
endinterface

// File: rtl/carry_skip_pipe.sv
// Pipelined carry-skip adder/subtractor: one BLOCK-wide slice is added per
// cycle, with the whole pipe stalling together under output backpressure.
module carry_skip_pipe #(
   parameter int WIDTH = 32,
   parameter int BLOCK = 4
) (
   input logic             clk,
   input logic             rst,
   carry_skip_pipe_if.slave bus
);
   localparam int BSAFE = (BLOCK > 0) ? BLOCK : 1;
   localparam int NB    = WIDTH / BSAFE;

   generate
      if (BLOCK < 1 || (WIDTH % BSAFE) != 0) begin : g_bad_cfg
         $error("carry_skip_pipe: WIDTH must be a positive multiple of BLOCK");
      end
   endgenerate

   logic             adv;
   logic [NB:0]      vld_p;
   logic [NB:0]      cy_p;
   logic [WIDTH-1:0] a_p   [NB];
   logic [WIDTH-1:0] b_p   [NB];
   logic [WIDTH-1:0] res_p [NB+1];
   logic [WIDTH-1:0] res_n [NB];
   logic [BLOCK-1:0] sum_c [NB];
   logic [NB-1:0]    cout_c;
   logic [NB-1:0]    cmsb_c;
   logic             ovf_p;

   // Returns {carry into block MSB, skipped block carry-out, block sum}.
   function automatic logic [BLOCK+1:0] blk_add(input logic [BLOCK-1:0] a,
                                               input logic [BLOCK-1:0] b,
                                               input logic             cin);
      logic [BLOCK:0]   rc;
      logic [BLOCK-1:0] p;
      logic [BLOCK-1:0] s;
      rc[0] = cin;
      for (int i = 0; i < BLOCK; i++) begin
         p[i]    = a[i] ^ b[i];
         s[i]    = p[i] ^ rc[i];
         rc[i+1] = (a[i] & b[i]) | (p[i] & rc[i]);
      end
      return {rc[BLOCK-1], ((&p) ? cin : rc[BLOCK]), s};
   endfunction

   always_comb begin
      for (int k = 0; k < NB; k++) begin
         {cmsb_c[k], cout_c[k], sum_c[k]} =
            blk_add(a_p[k][k*BLOCK +: BLOCK], b_p[k][k*BLOCK +: BLOCK], cy_p[k]);
         res_n[k]                  = res_p[k];
         res_n[k][k*BLOCK +: BLOCK] = sum_c[k];
      end
   end

   assign adv          = !vld_p[NB] || bus.out_ready;
   assign bus.in_ready = adv && !rst;

   always_ff @(posedge clk) begin
      if (rst) begin
         vld_p     <= '0;
         res_p[NB] <= '0;
         cy_p[NB]  <= 1'b0;
         ovf_p     <= 1'b0;
      end else if (adv) begin
         // capture: operands are pre-inverted for subtract so every stage just adds
         vld_p[0] <= bus.in_valid;
         a_p[0]   <= bus.operand1;
         b_p[0]   <= bus.sub ? ~bus.operand2 : bus.operand2;
         cy_p[0]  <= bus.Cin ^ bus.sub;
         res_p[0] <= '0;
         // stage k -> k+1: one slice resolved, its carry handed on
         for (int k = 0; k < NB; k++) begin
            vld_p[k+1] <= vld_p[k];
            cy_p[k+1]  <= cout_c[k];
            res_p[k+1] <= res_n[k];
         end
         for (int k = 1; k < NB; k++) begin
            a_p[k] <= a_p[k-1];
            b_p[k] <= b_p[k-1];
         end
         ovf_p <= cmsb_c[NB-1] ^ cout_c[NB-1];
      end
   end

   assign bus.out_valid = vld_p[NB];
   assign bus.Result    = res_p[NB];
   assign bus.Cout      = cy_p[NB];
   assign bus.Overflow  = ovf_p;
endmodule

// File: tb/tb_carry_skip_pipe.sv
// Directed and randomized self-checking bench for carry_skip_pipe
// at WIDTH=16, BLOCK=4 (four-cycle latency).
module tb_carry_skip_pipe;
   localparam int W   = 16;
   localparam int B   = 4;
   localparam int LAT = 4;

   logic clk = 1'b0;
   logic rst;
   int   tests = 0;
   int   fails = 0;

   always #5 clk = ~clk;

   carry_skip_pipe_if #(.WIDTH(W)) bus();

   carry_skip_pipe #(.WIDTH(W), .BLOCK(B)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic [15:0] a, input logic [15:0] b, input logic c, input logic s);
      bus.in_valid = 1'b1;
      bus.operand1 = a;
      bus.operand2 = b;
      bus.Cin      = c;
      bus.sub      = s;
   endtask

   // Independent reference: {Cout, Overflow, Result}
   function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b,
                                         input logic c, input logic s);
      logic [15:0] be;
      logic [16:0] sum;
      logic        ov;
      be  = s ? ~b : b;
      sum = {1'b0, a} + {1'b0, be} + {16'b0, c ^ s};
      ov  = (a[15] == be[15]) && (sum[15] != a[15]);
      return {sum[16], ov, sum[15:0]};
   endfunction

   task automatic run_one(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic c, input logic s, input logic [17:0] exp);
      int n;
      @(negedge clk);
      drive(a, b, c, s);
      bus.out_ready = 1'b1;
      #1;
      chk({tag, "_rdy"}, 32'(bus.in_ready), 32'd1);
      @(negedge clk);
      bus.in_valid = 1'b0;
      n = 0;
      while (!bus.out_valid && n < 12) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_lat"}, 32'(n), 32'(LAT));
      chk({tag, "_res"}, 32'({bus.Cout, bus.Overflow, bus.Result}), 32'(exp));
   endtask

   logic [15:0] sa [6];
   logic [15:0] se [6];
   logic [15:0] ra, rb, held;
   logic        rc, rs, seen;
   logic [17:0] e;
   logic [17:0] q [$];
   int          tx, rx, stall, acc, got;

   initial begin
      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.operand1  = '0;
      bus.operand2  = '0;
      bus.Cin       = 1'b0;
      bus.sub       = 1'b0;
      bus.out_ready = 1'b1;

      // reset state
      @(negedge clk);
      @(negedge clk);
      chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_result", 32'(bus.Result), 32'd0);
      chk("rst_cout_ovf", 32'({bus.Cout, bus.Overflow}), 32'd0);
      rst = 1'b0;
      #1;
      chk("post_rst_ready", 32'(bus.in_ready), 32'd1);

      // directed arithmetic vectors
      run_one("ffff_p1",  16'hFFFF, 16'h0001, 1'b0, 1'b0, {1'b1, 1'b0, 16'h0000});
      run_one("5_m_7",    16'h0005, 16'h0007, 1'b0, 1'b1, {1'b0, 1'b0, 16'hFFFE});
      run_one("8000_m1",  16'h8000, 16'h0001, 1'b0, 1'b1, {1'b1, 1'b1, 16'h7FFF});
      run_one("7fff_p1",  16'h7FFF, 16'h0001, 1'b0, 1'b0, {1'b0, 1'b1, 16'h8000});
      run_one("skipall",  16'hAAAA, 16'h5555, 1'b1, 1'b0, {1'b1, 1'b0, 16'h0000});
      run_one("plain",    16'h1234, 16'h4321, 1'b0, 1'b0, {1'b0, 1'b0, 16'h5555});
      run_one("0_m_0",    16'h0000, 16'h0000, 1'b0, 1'b1, {1'b1, 1'b0, 16'h0000});
      run_one("borrow",   16'h0005, 16'h0003, 1'b1, 1'b1, {1'b1, 1'b0, 16'h0001});

      // six back-to-back inputs, 5-cycle output stall at first result
      sa = '{16'h0000, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555};
      se = '{16'h0101, 16'h1212, 16'h2323, 16'h3434, 16'h4545, 16'h5656};
      tx = 0; rx = 0; stall = 0; seen = 1'b0; held = '0;
      for (int c = 0; c < 40 && rx < 6; c++) begin
         @(negedge clk);
         if (bus.out_valid && !seen) begin
            seen  = 1'b1;
            stall = 5;
         end
         bus.out_ready = (stall == 0);
         if (tx < 6) drive(sa[tx], 16'h0101, 1'b0, 1'b0);
         else        bus.in_valid = 1'b0;
         #1;
         if (stall > 0) begin
            chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
            if (stall < 5) chk("stall_hold", 32'(bus.Result), 32'(held));
            else           chk("stall_first", 32'(bus.Result), 32'(se[0]));
            held = bus.Result;
            stall--;
         end
         if (bus.out_valid && bus.out_ready) begin
            chk("stall_res", 32'({bus.Cout, bus.Overflow, bus.Result}), 32'({2'b00, se[rx]}));
            rx++;
         end else if (seen && stall == 0) begin
            chk("stall_gap", 32'(bus.out_valid), 32'd1);
         end
         if (bus.in_valid && bus.in_ready) tx++;
      end
      chk("stall_count", 32'(rx), 32'd6);
      @(negedge clk);
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;

      // reset with three operand sets in flight
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         drive(16'(i + 1), 16'h0100, 1'b0, 1'b0);
      end
      @(negedge clk);
      bus.in_valid = 1'b0;
      rst          = 1'b1;
      #1;
      chk("midrst_in_ready", 32'(bus.in_ready), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      chk("midrst_result", 32'(bus.Result), 32'd0);
      seen = 1'b0;
      for (int i = 0; i < 6; i++) begin
         if (bus.out_valid) seen = 1'b1;
         @(negedge clk);
      end
      chk("midrst_no_out", 32'(seen), 32'd0);
      run_one("post_midrst", 16'h1111, 16'h2222, 1'b0, 1'b0, {1'b0, 1'b0, 16'h3333});

      // random traffic against the reference model
      acc = 0; got = 0;
      for (int c = 0; c < 60000 && got < 10000; c++) begin
         @(negedge clk);
         bus.out_ready = ($urandom_range(3) != 0);
         if (acc < 10000 && $urandom_range(3) != 0) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rc = 1'($urandom_range(1));
            rs = 1'($urandom_range(1));
            drive(ra, rb, rc, rs);
         end else begin
            bus.in_valid = 1'b0;
         end
         #1;
         if (bus.out_valid && bus.out_ready) begin
            if (q.size() != 0) e = q.pop_front();
            else               e = 'x;
            chk("rnd", 32'({bus.Cout, bus.Overflow, bus.Result}), 32'(e));
            got++;
         end
         if (bus.in_valid && bus.in_ready) begin
            q.push_back(model(bus.operand1, bus.operand2, bus.Cin, bus.sub));
            acc++;
         end
      end
      chk("rnd_done", 32'(got), 32'd10000);
      bus.in_valid = 1'b0;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
